prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Downstream stage of the LFSR pattern generator; consumes its serial bit stream (data/valid) and verifies it against the same feedback polynomial.
- Self-synchronises from the received stream, declares lock, then counts bit errors and bits checked.
- Used for link and loopback BER tests; sits at the receive side of a serial path.

Parameters:
- N, 8, LFSR length in bits; must match the generator.
- TAPS, 8'b00000011, feedback tap mask (bit i set = state bit i feeds parity); must match the generator.
- LOCK_COUNT, 16, consecutive correct predictions required in VERIFY before LOCKED (1..255).
- UNLOCK_ERRORS, 4, consecutive mismatches in LOCKED that force return to HUNT (1..255).
- CNT_W, 32, width of the error and bit counters.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous active-high reset
- data_i  input  1  received serial bit (generator data output)
- valid_i  input  1  data_i qualifier; bits are consumed only when high
- clear_i  input  1  synchronous clear of err_count_o and bit_count_o; does not affect lock state
- locked_o  output  1  high while in LOCKED
- err_o  output  1  one-cycle pulse per mismatching bit while LOCKED
- err_count_o  output  CNT_W  saturating count of mismatches while LOCKED
- bit_count_o  output  CNT_W  saturating count of bits checked while LOCKED

Behaviour:
- Reset (async assert, sync release): state HUNT, window 0, fill/match/mismatch counters 0, all outputs 0.
- Window W[N-1:0]: the newest bit enters at W[N-1] and older bits shift toward W[0], matching the generator's right shift. Predicted next bit p = XOR-reduce(W & TAPS).
- The FSM advances only on cycles with valid_i=1; on valid_i=0 all state holds and err_o=0.
- HUNT:
  - Shift data_i into W and increment the fill counter.
  - After N valid bits, go to VERIFY with the match counter at 0.
- VERIFY:
  - Compare data_i with p, then shift data_i into W (self-synchronising).
  - On a match, increment the match counter; on reaching LOCK_COUNT, go to LOCKED.
  - On a mismatch, reset the match counter to 0 and stay in VERIFY.
- LOCKED:
  - Shift p (not data_i) into W, so W free-runs as the reference and each bit error counts once.
  - Every valid bit increments bit_count_o.
  - On a mismatch: err_o=1 next cycle, err_count_o increments, and the consecutive-mismatch counter increments.
  - On a match, the consecutive-mismatch counter clears.
  - When the consecutive-mismatch counter reaches UNLOCK_ERRORS, go to HUNT with the fill counter at 0. The bit that triggers unlock is still counted.
- Latency: locked_o, err_o and both counters are registered and update in the cycle after the valid_i beat that caused them.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- clear_i together with a counted error in the same cycle: clear wins and the counter reads 0. err_o still pulses.
- An all-zero stream in LOCKED with an all-zero window is a legal degenerate lock. The generator never produces it for nonzero seeds, and the checker does not special-case it.
- Reset mid-operation: immediate return to the reset state regardless of FSM state.

Optional Feature:
- Macro: PRBS_CHECKER_VARIABLE_TAPS_EN.
- Defined:
  - Adds input ports taps_i [N-1:0] and load_config_i (1).
  - load_config_i=1 latches taps_i into an internal taps register, forces HUNT, clears all counters and outputs, and consumes no data that cycle.
  - The taps register resets to TAPS.
- Undefined:
  - Ports are absent and the TAPS parameter is used as a constant.

Decomposition:
- Package prbs_pkg:
  - state enum {HUNT, VERIFY, LOCKED} (2-bit);
  - parity function (XOR-reduce of state & taps) shared with future generator variants;
  - default TAPS constant.
- No sub-module; a single module with one FSM and counter process.

Test Plan:
- Generator (N=8, TAPS=8'h03, seed 8'h01) feeds the checker continuously -> locked_o rises 8+16=24 valid beats after the first bit (plus one register cycle); err_count_o stays 0; after 1000 further beats bit_count_o=1000.
- Locked stream with a single bit flipped -> exactly one err_o pulse, err_count_o=1, locked_o stays 1.
- Locked, then 4 consecutive flipped bits -> err_count_o=4, locked_o falls on the cycle after the 4th error, then relocks after 24 clean beats.
- valid_i toggling 1/0 every cycle with a clean stream -> lock after 24 valid beats (48 cycles); no err_o on invalid cycles.
- clear_i asserted in the same cycle as a counted error -> err_count_o=0, err_o=1; reset_i asserted while LOCKED -> all outputs 0 in the same cycle.
- With PRBS_CHECKER_VARIABLE_TAPS_EN: load taps 8'hB8 and feed a matching generator -> locks; load 8'h03 mid-stream -> locked_o=0 and counters=0 on the next cycle.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS pattern checker and future generator variants.
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    localparam logic [7:0] DEFAULT_TAPS = 8'b0000_0011;
    localparam int PARITY_MAX_W = 64;

    // Callers zero-extend narrower windows/masks; unused high bits drop out of the AND.
    function automatic logic parity(input logic [PARITY_MAX_W-1:0] win,
                                    input logic [PARITY_MAX_W-1:0] taps);
        return ^(win & taps);
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: HUNT -> VERIFY -> LOCKED, then counts bit errors.
// Optional runtime tap selection when PRBS_CHECKER_VARIABLE_TAPS_EN is defined.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int             N             = 8,
    parameter logic [N-1:0]   TAPS          = N'(DEFAULT_TAPS),
    parameter int             LOCK_COUNT    = 16,
    parameter int             UNLOCK_ERRORS = 4,
    parameter int             CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             data_i,
    input  logic             valid_i,
    input  logic             clear_i,
`ifdef PRBS_CHECKER_VARIABLE_TAPS_EN
    input  logic [N-1:0]     taps_i,
    input  logic             load_config_i,
`endif
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] bit_count_o
);

    localparam int FILL_W = $clog2(N + 1);

    prbs_state_e       state_q, state_d;
    logic [N-1:0]      win_q, win_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [7:0]        match_q, match_d;
    logic [7:0]        miss_q, miss_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [N-1:0]      taps_cur;
    logic              load;
    logic              pred;
    logic              cnt_err;
    logic              cnt_bit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef PRBS_CHECKER_VARIABLE_TAPS_EN
    logic [N-1:0] taps_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            taps_q <= TAPS;
        end else if (load_config_i) begin
            taps_q <= taps_i;
        end
    end

    assign taps_cur = taps_q;
    assign load     = load_config_i;
`else
    assign taps_cur = TAPS;
    assign load     = 1'b0;
`endif

    assign pred = parity(PARITY_MAX_W'(win_q), PARITY_MAX_W'(taps_cur));

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        cnt_err = 1'b0;
        cnt_bit = 1'b0;
        if (load) begin
            state_d = HUNT;
            win_d   = '0;
            fill_d  = '0;
            match_d = '0;
            miss_d  = '0;
        end else if (valid_i) begin
            case (state_q)
                HUNT: begin
                    win_d = {data_i, win_q[N-1:1]};
                    if (fill_q == FILL_W'(N - 1)) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                VERIFY: begin
                    win_d = {data_i, win_q[N-1:1]};
                    if (data_i == pred) begin
                        if (match_q == 8'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // The reference free-runs on its own prediction so a flipped
                    // bit cannot corrupt the window and cascade into more errors.
                    win_d   = {pred, win_q[N-1:1]};
                    cnt_bit = 1'b1;
                    if (data_i != pred) begin
                        err_d   = 1'b1;
                        cnt_err = 1'b1;
                        if (miss_q == 8'(UNLOCK_ERRORS - 1)) begin
                            state_d = HUNT;
                            fill_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        err_cnt_d = cnt_err ? sat_inc(err_cnt_q) : err_cnt_q;
        bit_cnt_d = cnt_bit ? sat_inc(bit_cnt_q) : bit_cnt_q;
        if (clear_i || load) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= HUNT;
            win_q     <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign locked_o    = (state_q == LOCKED);
    assign err_o       = err_q;
    assign err_count_o = err_cnt_q;
    assign bit_count_o = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: an LFSR generator drives the DUT, a beat-level model predicts outputs.
// A second instance with 4-bit counters exercises counter saturation.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        data;
    logic        valid;
    logic        clear;
    logic        locked, err, locked_s, err_s;
    logic [31:0] err_cnt, bit_cnt;
    logic [3:0]  err_cnt_s, bit_cnt_s;
`ifdef PRBS_CHECKER_VARIABLE_TAPS_EN
    logic [7:0]  taps;
    logic        load_cfg;
`endif

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk_i(clk), .reset_i(reset), .data_i(data), .valid_i(valid), .clear_i(clear),
`ifdef PRBS_CHECKER_VARIABLE_TAPS_EN
        .taps_i(taps), .load_config_i(load_cfg),
`endif
        .locked_o(locked), .err_o(err), .err_count_o(err_cnt), .bit_count_o(bit_cnt)
    );

    prbs_checker #(.CNT_W(4)) dut_s (
        .clk_i(clk), .reset_i(reset), .data_i(data), .valid_i(valid), .clear_i(clear),
`ifdef PRBS_CHECKER_VARIABLE_TAPS_EN
        .taps_i(taps), .load_config_i(load_cfg),
`endif
        .locked_o(locked_s), .err_o(err_s), .err_count_o(err_cnt_s), .bit_count_o(bit_cnt_s)
    );

    typedef struct {
        logic        l;
        logic        e;
        logic [31:0] ec;
        logic [31:0] bc;
        logic [3:0]  ecs;
        logic [3:0]  bcs;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Generator state and beat-level reference state
    logic [7:0]  gen_s    = 8'h01;
    logic [7:0]  gen_taps = 8'h03;
    bit          m_locked = 0;
    int          m_since  = 0;
    int          m_consec = 0;
    logic [31:0] m_ec = 0, m_bc = 0;
    logic [3:0]  m_ecs = 0, m_bcs = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("locked",     32'(locked),    32'(e.l));
            check_eq("err",        32'(err),       32'(e.e));
            check_eq("err_count",  err_cnt,        e.ec);
            check_eq("bit_count",  bit_cnt,        e.bc);
            check_eq("sat_err_count", 32'(err_cnt_s), 32'(e.ecs));
            check_eq("sat_bit_count", 32'(bit_cnt_s), 32'(e.bcs));
        end
    endtask

    function automatic logic [3:0] inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // One clock: compare the previous beat's outputs, then drive a new beat.
    task automatic drive(input bit v, input bit f, input bit c, input bit ld, input logic [7:0] t);
        exp_t e;
        logic gb;
        bit   errp;
        @(negedge clk);
        pop_compare();
        errp = 0;
`ifdef PRBS_CHECKER_VARIABLE_TAPS_EN
        load_cfg = ld;
        taps     = t;
`endif
        valid = v;
        clear = c;
        if (v && !ld) begin
            gb    = ^(gen_s & gen_taps);
            gen_s = {gb, gen_s[7:1]};
            data  = gb ^ f;
        end else begin
            data = 1'($urandom_range(0, 1));
        end
        if (ld) begin
            m_locked = 0; m_since = 0; m_consec = 0;
            m_ec = 0; m_bc = 0; m_ecs = 0; m_bcs = 0;
        end else if (v) begin
            if (!m_locked) begin
                m_since++;
                if (m_since == 24) begin
                    m_locked = 1;
                    m_consec = 0;
                end
            end else begin
                m_bc++;
                m_bcs = inc4(m_bcs);
                if (f) begin
                    errp = 1;
                    m_ec++;
                    m_ecs = inc4(m_ecs);
                    m_consec++;
                    if (m_consec == 4) begin
                        m_locked = 0;
                        m_since  = 0;
                        m_consec = 0;
                    end
                end else begin
                    m_consec = 0;
                end
            end
        end
        if (c) begin
            m_ec = 0; m_bc = 0; m_ecs = 0; m_bcs = 0;
        end
        e.l = m_locked; e.e = errp; e.ec = m_ec; e.bc = m_bc; e.ecs = m_ecs; e.bcs = m_bcs;
        sb.push_back(e);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pop_compare();
        reset = 1'b1;
        valid = 1'b0;
        clear = 1'b0;
        #1;
        check_eq("rst_locked",    32'(locked), 0);
        check_eq("rst_err",       32'(err),    0);
        check_eq("rst_err_count", err_cnt,     0);
        check_eq("rst_bit_count", bit_cnt,     0);
        m_locked = 0; m_since = 0; m_consec = 0;
        m_ec = 0; m_bc = 0; m_ecs = 0; m_bcs = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        data  = 1'b0;
        valid = 1'b0;
        clear = 1'b0;
`ifdef PRBS_CHECKER_VARIABLE_TAPS_EN
        taps     = 8'h00;
        load_cfg = 1'b0;
`endif
        #1;
        check_eq("init_locked",    32'(locked), 0);
        check_eq("init_err",       32'(err),    0);
        check_eq("init_err_count", err_cnt,     0);
        check_eq("init_bit_count", bit_cnt,     0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Acquisition and a long clean run (also saturates the 4-bit instance)
        clean(24 + 1000);
        // Single flipped bit
        drive(1, 1, 0, 0, 8'h00);
        clean(20);
        // Four consecutive errors force unlock, then relock on clean data
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 8'h00);
        clean(30);
        // Clear coincident with a counted error
        drive(1, 1, 1, 0, 8'h00);
        clean(5);
        // Reset while locked
        do_reset();
        // Alternating valid with a clean stream
        for (int i = 0; i < 30; i++) begin
            drive(1, 0, 0, 0, 8'h00);
            drive(0, 0, 0, 0, 8'h00);
        end
`ifdef PRBS_CHECKER_VARIABLE_TAPS_EN
        drive(1, 0, 0, 1, 8'hB8);
        gen_taps = 8'hB8;
        gen_s    = 8'h01;
        clean(40);
        drive(1, 1, 0, 0, 8'h00);
        clean(3);
        drive(1, 0, 0, 1, 8'h03);
        drive(0, 0, 0, 0, 8'h00);
`endif
        @(negedge clk);
        pop_compare();
        check_eq("queue_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
